// File: rtl/fpga_prog_pkg.sv
// Shared types and constants for the eFPGA bitstream loader.
// Optional feature macro: PROG_CHECKSUM_EN (adds per-frame checksum word).
package fpga_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } prog_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SYNC     = 2'd1,
        ERR_INDEX    = 2'd2,
        ERR_CHECKSUM = 2'd3
    } err_code_t;

    localparam logic [7:0] PROG_SYNC    = 8'hA5;
    localparam logic [7:0] PROG_END_IDX = 8'hFF;

    // Header word layout: [31:24] sync, [23:16] chain index, [15:0] word count
    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_IDX_LSB  = 16;
    localparam int HDR_CNT_LSB  = 0;
    localparam int HDR_CNT_W    = 16;

    // One-bit left rotate used by the running checksum
    function automatic logic [31:0] rotl1(input logic [31:0] v);
        return {v[30:0], v[31]};
    endfunction

endpackage

// File: rtl/prog_chk.sv
// Running checksum accumulator for one configuration frame.
// Only instantiated when PROG_CHECKSUM_EN is defined.
module prog_chk
    import fpga_prog_pkg::*;
(
    input  logic        clk,
    input  logic        nres,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [31:0] chk_q;
    logic [31:0] chk_d;

    // Clear at each header, otherwise fold in one payload word per enable
    always_comb begin
        chk_d = chk_q;
        if (clear) begin
            chk_d = '0;
        end else if (enable) begin
            chk_d = rotl1(chk_q) ^ word;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign value = chk_q;

endmodule

// File: rtl/fpga_prog_ctrl.sv
// Bitstream loader: parses framed config stream and drives the fabric
// programming word bus and one-hot per-chain shift enables.
// Optional feature macro: PROG_CHECKSUM_EN (checksum word after each frame).
module fpga_prog_ctrl
    import fpga_prog_pkg::*;
#(
    parameter int H  = 2,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              nres,
    input  logic              start,
    input  logic [DW-1:0]     bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic [DW-1:0]     prog_o,
    output logic [2*H:0]      prog_shft,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              fabric_en
);

    localparam int CHAINS = 2 * H + 1;
    localparam int IDX_W  = (CHAINS > 1) ? $clog2(CHAINS) : 1;

`ifdef PROG_CHECKSUM_EN
    localparam prog_state_t FRAME_END = ST_CHK;
`else
    localparam prog_state_t FRAME_END = ST_HDR;
`endif

    prog_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HDR_CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]       prog_q, prog_d;
    logic [CHAINS-1:0]   shft_q, shft_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                fen_q, fen_d;
    err_code_t           code_q, code_d;

    logic                hs;
    logic [7:0]          hdr_sync;
    logic [7:0]          hdr_idx;
    logic [HDR_CNT_W-1:0] hdr_cnt;

    assign hs       = bs_valid & ready_q;
    assign hdr_sync = bs_data[HDR_SYNC_LSB +: 8];
    assign hdr_idx  = bs_data[HDR_IDX_LSB +: 8];
    assign hdr_cnt  = bs_data[HDR_CNT_LSB +: HDR_CNT_W];

`ifdef PROG_CHECKSUM_EN
    logic        chk_clear;
    logic        chk_en;
    logic [31:0] chk_value;

    prog_chk u_chk (
        .clk    (clk),
        .nres   (nres),
        .clear  (chk_clear),
        .enable (chk_en),
        .word   (bs_data[31:0]),
        .value  (chk_value)
    );
`endif

    // Next-state and registered-output computation for the loader FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        prog_d  = prog_q;
        shft_d  = '0;
        done_d  = done_q;
        err_d   = err_q;
        fen_d   = fen_q;
        code_d  = code_q;
`ifdef PROG_CHECKSUM_EN
        chk_clear = 1'b0;
        chk_en    = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    fen_d   = 1'b0;
                    code_d  = ERR_NONE;
                end
            end
            ST_HDR: begin
                if (hs) begin
                    if (hdr_sync != PROG_SYNC) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        code_d  = ERR_SYNC;
                    end else if (hdr_idx == PROG_END_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        fen_d   = 1'b1;
                    end else if (hdr_idx > 8'(2 * H)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        code_d  = ERR_INDEX;
                    end else begin
                        idx_d = hdr_idx[IDX_W-1:0];
                        cnt_d = hdr_cnt;
`ifdef PROG_CHECKSUM_EN
                        chk_clear = 1'b1;
`endif
                        state_d = (hdr_cnt == '0) ? FRAME_END : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    prog_d = bs_data;
                    shft_d = CHAINS'(1) << idx_q;
                    cnt_d  = cnt_q - 16'd1;
`ifdef PROG_CHECKSUM_EN
                    chk_en = 1'b1;
`endif
                    if (cnt_q == 16'd1) begin
                        state_d = FRAME_END;
                    end
                end
            end
`ifdef PROG_CHECKSUM_EN
            ST_CHK: begin
                if (hs) begin
                    if (bs_data[31:0] == chk_value) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        code_d  = ERR_CHECKSUM;
                    end
                end
            end
`endif
            default: begin
            end
        endcase
        ready_d = (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_CHK);
        busy_d  = ready_d;
    end

    // FSM state, counters and all outputs registered together
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            prog_q  <= '0;
            shft_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fen_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            prog_q  <= prog_d;
            shft_q  <= shft_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fen_q   <= fen_d;
            code_q  <= code_d;
        end
    end

    assign bs_ready  = ready_q;
    assign prog_o    = prog_q;
    assign prog_shft = shft_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign fabric_en = fen_q;

endmodule

// File: tb/tb_fpga_prog_ctrl.sv
// Self-checking bench for fpga_prog_ctrl (H=2, DW=32).
// Payload words are pushed to a scoreboard at handshake and compared
// against prog_o/prog_shft when the pulse appears.
module tb_fpga_prog_ctrl;

    localparam int H      = 2;
    localparam int DW     = 32;
    localparam int CHAINS = 2 * H + 1;

    // Status packing: {busy, bs_ready, done, err, fabric_en, err_code[1:0]}
    localparam logic [6:0] ST_RST   = 7'b0000000;
    localparam logic [6:0] ST_BUSY  = 7'b1100000;
    localparam logic [6:0] ST_DONEV = 7'b0010100;
    localparam logic [6:0] ST_ESYNC = 7'b0001001;
    localparam logic [6:0] ST_EIDX  = 7'b0001010;
    localparam logic [6:0] ST_ECHK  = 7'b0001011;

    logic              clk = 1'b0;
    logic              nres;
    logic              start;
    logic [DW-1:0]     bs_data;
    logic              bs_valid;
    logic              bs_ready;
    logic [DW-1:0]     prog_o;
    logic [CHAINS-1:0] prog_shft;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic              fabric_en;
    logic [6:0]        status;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulse_count = 0;
    int pulse_cyc[$];

    typedef struct {
        logic [CHAINS-1:0] shft;
        logic [DW-1:0]     word;
    } exp_t;
    exp_t exp_q[$];

    assign status = {busy, bs_ready, done, err, fabric_en, err_code};

    fpga_prog_ctrl #(.H(H), .DW(DW)) dut (
        .clk       (clk),
        .nres      (nres),
        .start     (start),
        .bs_data   (bs_data),
        .bs_valid  (bs_valid),
        .bs_ready  (bs_ready),
        .prog_o    (prog_o),
        .prog_shft (prog_shft),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .fabric_en (fabric_en)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Cycle counter used to measure pulse spacing
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every shift pulse must match the oldest expected payload
    always @(negedge clk) begin
        exp_t e;
        if (prog_shft !== '0) begin
            pulse_count++;
            pulse_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse shft=%b word=%h expected no pulse", prog_shft, prog_o);
            end else begin
                e = exp_q.pop_front();
                if (prog_shft !== e.shft || prog_o !== e.word) begin
                    failures++;
                    $display("[TB] FAIL payload got shft=%b word=%h expected shft=%b word=%h",
                             prog_shft, prog_o, e.shft, e.word);
                end
            end
        end
    end

    // Safety net against a hung bench
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Present one word and hold it until accepted (bounded wait)
    task automatic send_word(input logic [31:0] w, input bit payload, input int chain);
        bit   ok;
        exp_t e;
        ok       = 1'b0;
        bs_data  = w;
        bs_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bs_ready === 1'b1) begin
                if (payload) begin
                    e.shft = CHAINS'(1) << chain;
                    e.word = w;
                    exp_q.push_back(e);
                end
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bs_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL handshake_timeout word=%h got no bs_ready expected bs_ready=1", w);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        nres = 1'b0; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
        idle(2);
        checks++;
        if (status !== ST_RST || prog_shft !== '0 || prog_o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_values got status=%b shft=%b prog=%h expected all zero", status, prog_shft, prog_o);
        end
        nres = 1'b1;
        bs_data  = 32'hA5000001;
        bs_valid = 1'b1;
        idle(3);
        bs_valid = 1'b0;
        checks++;
        if (status !== ST_RST) begin
            failures++;
            $display("[TB] FAIL idle_ignores_valid got status=%b expected %b", status, ST_RST);
        end
    endtask

    task automatic test_basic_load();
        int pc0;
        pulse_start();
        checks++;
        if (status !== ST_BUSY) begin
            failures++;
            $display("[TB] FAIL start_to_hdr got status=%b expected %b", status, ST_BUSY);
        end
        pc0 = pulse_cyc.size();
        send_word(32'hA5030002, 0, 0);
        send_word(32'h11111111, 1, 3);
        send_word(32'h22222222, 1, 3);
        send_word(32'hA5FF0000, 0, 0);
        checks++;
        if (status !== ST_DONEV) begin
            failures++;
            $display("[TB] FAIL basic_done got status=%b expected %b", status, ST_DONEV);
        end
        checks++;
        if (prog_o !== 32'h22222222 || prog_shft !== '0) begin
            failures++;
            $display("[TB] FAIL prog_hold got prog=%h shft=%b expected 22222222 00000", prog_o, prog_shft);
        end
        checks++;
        if (pulse_cyc.size() != pc0 + 2 || pulse_cyc[pc0 + 1] - pulse_cyc[pc0] != 1) begin
            failures++;
            $display("[TB] FAIL basic_consecutive got pulses=%0d expected 2 consecutive", pulse_cyc.size() - pc0);
        end
    endtask

    task automatic test_bad_sync();
        pulse_start();
        checks++;
        if (status !== ST_BUSY) begin
            failures++;
            $display("[TB] FAIL restart_clears got status=%b expected %b", status, ST_BUSY);
        end
        send_word(32'h5A000001, 0, 0);
        checks++;
        if (status !== ST_ESYNC) begin
            failures++;
            $display("[TB] FAIL bad_sync got status=%b expected %b", status, ST_ESYNC);
        end
        bs_data  = 32'h11223344;
        bs_valid = 1'b1;
        idle(3);
        bs_valid = 1'b0;
        checks++;
        if (status !== ST_ESYNC) begin
            failures++;
            $display("[TB] FAIL err_hold got status=%b expected %b", status, ST_ESYNC);
        end
    endtask

    task automatic test_bad_index();
        pulse_start();
        send_word(32'hA5050001, 0, 0);
        checks++;
        if (status !== ST_EIDX) begin
            failures++;
            $display("[TB] FAIL bad_index got status=%b expected %b", status, ST_EIDX);
        end
        bs_data  = 32'hCAFEF00D;
        bs_valid = 1'b1;
        idle(3);
        bs_valid = 1'b0;
    endtask

`ifdef PROG_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_word(32'hA5000002, 0, 0);
        send_word(32'h00000001, 1, 0);
        send_word(32'h00000001, 1, 0);
        send_word(32'h00000003, 0, 0);
        checks++;
        if (status !== ST_BUSY) begin
            failures++;
            $display("[TB] FAIL checksum_match got status=%b expected %b", status, ST_BUSY);
        end
        send_word(32'hA5010002, 0, 0);
        send_word(32'h00000001, 1, 1);
        send_word(32'h00000001, 1, 1);
        send_word(32'h00000002, 0, 0);
        checks++;
        if (status !== ST_ECHK) begin
            failures++;
            $display("[TB] FAIL checksum_mismatch got status=%b expected %b", status, ST_ECHK);
        end
    endtask
`else
    task automatic test_frame_end();
        pulse_start();
        send_word(32'hA5000001, 0, 0);
        send_word(32'hDEADBEEF, 1, 0);
        checks++;
        if (status !== ST_BUSY) begin
            failures++;
            $display("[TB] FAIL frame_back_to_hdr got status=%b expected %b", status, ST_BUSY);
        end
        send_word(32'hA5010000, 0, 0);
        checks++;
        if (status !== ST_BUSY) begin
            failures++;
            $display("[TB] FAIL zero_len_frame got status=%b expected %b", status, ST_BUSY);
        end
        send_word(32'hA5FF1234, 0, 0);
        checks++;
        if (status !== ST_DONEV) begin
            failures++;
            $display("[TB] FAIL end_ignores_n got status=%b expected %b", status, ST_DONEV);
        end
    endtask
`endif

    task automatic test_stall();
        logic [31:0] words [4];
        int pc;
        words[0] = 32'h0000A001; words[1] = 32'h0000B002;
        words[2] = 32'h0000C003; words[3] = 32'h0000D004;
        pulse_start();
        pc = pulse_count;
        send_word(32'hA5000004, 0, 0);
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], 1, 0);
            idle(1);
        end
        idle(1);
        checks++;
        if (pulse_count - pc != 4 || status !== ST_BUSY) begin
            failures++;
            $display("[TB] FAIL stall_pulses got pulses=%0d status=%b expected 4 %b", pulse_count - pc, status, ST_BUSY);
        end
        send_word(32'hA5FF0000, 0, 0);
        checks++;
        if (status !== ST_DONEV) begin
            failures++;
            $display("[TB] FAIL stall_done got status=%b expected %b", status, ST_DONEV);
        end
    endtask

    task automatic test_back_to_back();
        int pc0;
        pulse_start();
        pc0 = pulse_cyc.size();
        send_word(32'hA5010002, 0, 0);
        send_word(32'hAAAA0001, 1, 1);
        send_word(32'hAAAA0002, 1, 1);
        send_word(32'hA5040002, 0, 0);
        send_word(32'hBBBB0001, 1, 4);
        send_word(32'hBBBB0002, 1, 4);
        send_word(32'hA5FF0000, 0, 0);
        checks++;
        if (pulse_cyc.size() != pc0 + 4) begin
            failures++;
            $display("[TB] FAIL b2b_count got %0d expected 4", pulse_cyc.size() - pc0);
        end else if (pulse_cyc[pc0 + 1] - pulse_cyc[pc0] != 1 ||
                     pulse_cyc[pc0 + 2] - pulse_cyc[pc0 + 1] != 2 ||
                     pulse_cyc[pc0 + 3] - pulse_cyc[pc0 + 2] != 1) begin
            failures++;
            $display("[TB] FAIL b2b_spacing got gaps %0d %0d %0d expected 1 2 1",
                     pulse_cyc[pc0 + 1] - pulse_cyc[pc0], pulse_cyc[pc0 + 2] - pulse_cyc[pc0 + 1],
                     pulse_cyc[pc0 + 3] - pulse_cyc[pc0 + 2]);
        end
        checks++;
        if (status !== ST_DONEV) begin
            failures++;
            $display("[TB] FAIL b2b_done got status=%b expected %b", status, ST_DONEV);
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_word(32'hA5020003, 0, 0);
        send_word(32'h12345678, 1, 2);
        idle(1);
        #2 nres = 1'b0;
        #1;
        checks++;
        if (status !== ST_RST || prog_shft !== '0 || prog_o !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset got status=%b shft=%b prog=%h expected all zero", status, prog_shft, prog_o);
        end
        @(negedge clk);
        nres = 1'b1;
        idle(1);
        checks++;
        if (status !== ST_RST) begin
            failures++;
            $display("[TB] FAIL post_reset_idle got status=%b expected %b", status, ST_RST);
        end
        pulse_start();
        send_word(32'hA5020002, 0, 0);
        send_word(32'h87654321, 1, 2);
        send_word(32'h0F0F0F0F, 1, 2);
        send_word(32'hA5FF0000, 0, 0);
        checks++;
        if (status !== ST_DONEV) begin
            failures++;
            $display("[TB] FAIL restart_done got status=%b expected %b", status, ST_DONEV);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_sync();
        test_bad_index();
`ifdef PROG_CHECKSUM_EN
        test_checksum();
`else
        test_frame_end();
`endif
        test_stall();
        test_back_to_back();
        test_reset_mid_load();
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
